// File: rtl/timing_generator.sv
// Detector panel timing generator: reset, integrate and raster readout
// of a clamped region of interest, one ADC strobe per pixel.
module timing_generator #(
    parameter int CYCLES_PER_MS = 100000,
    parameter int RESET_CYCLES  = 16,
    parameter int ROW_SETUP     = 8,
    parameter int COL_DIV       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        frame_reset,
    input  logic [15:0] integration_time,
    input  logic [11:0] row_start,
    input  logic [11:0] row_end,
    input  logic [11:0] col_start,
    input  logic [11:0] col_end,
    output logic        frame_busy,
    output logic        frame_complete,
    output logic [11:0] row_addr,
    output logic [11:0] col_addr,
    output logic        row_clk_en,
    output logic        col_clk_en,
    output logic        gate_sel,
    output logic        reset_pulse,
    output logic        adc_start_trigger
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET     = 3'd1,
        INTEGRATE = 3'd2,
        READOUT   = 3'd3,
        DONE      = 3'd4
    } state_e;

    localparam logic [31:0] RST_LAST   = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] MS_LAST    = 32'(CYCLES_PER_MS - 1);
    localparam logic [15:0] SETUP_LAST = 16'(ROW_SETUP - 1);
    localparam logic [15:0] DIV_LAST   = 16'(COL_DIV - 1);

    state_e      state, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] ms_q, ms_d;
    logic [15:0] ph_q, ph_d;
    logic        in_cols_q, in_cols_d;
    logic [11:0] row_q, row_d, col_q, col_d;
    logic [11:0] rs_q, rs_d, re_q, re_d;
    logic [11:0] cs_q, cs_d, ce_q, ce_d;
    logic [15:0] int_q, int_d;
    logic        enter_ro;
    logic        ro_d;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt_q;
        ms_d      = ms_q;
        ph_d      = ph_q;
        in_cols_d = in_cols_q;
        row_d     = row_q;
        col_d     = col_q;
        rs_d      = rs_q;
        re_d      = re_q;
        cs_d      = cs_q;
        ce_d      = ce_q;
        int_d     = int_q;
        enter_ro  = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    state_d = RESET;
                    cnt_d   = '0;
                    rs_d    = row_start;
                    re_d    = (row_end < row_start) ? row_start : row_end;
                    cs_d    = col_start;
                    ce_d    = (col_end < col_start) ? col_start : col_end;
                    int_d   = integration_time;
                end
            end
            RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = INTEGRATE;
                    cnt_d   = '0;
                    ms_d    = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            INTEGRATE: begin
                if (int_q == 16'd0) begin
                    enter_ro = 1'b1;
                end else if (cnt_q == MS_LAST) begin
                    cnt_d = '0;
                    if (ms_q == int_q - 16'd1) enter_ro = 1'b1;
                    else ms_d = ms_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            READOUT: begin
                // Row setup phase first, then one pixel per COL_DIV cycles.
                if (!in_cols_q) begin
                    if (ph_q == SETUP_LAST) begin
                        ph_d      = '0;
                        in_cols_d = 1'b1;
                    end else begin
                        ph_d = ph_q + 16'd1;
                    end
                end else if (ph_q == DIV_LAST) begin
                    ph_d = '0;
                    if (col_q == ce_q) begin
                        if (row_q == re_q) begin
                            state_d = DONE;
                        end else begin
                            row_d     = row_q + 12'd1;
                            col_d     = cs_q;
                            in_cols_d = 1'b0;
                        end
                    end else begin
                        col_d = col_q + 12'd1;
                    end
                end else begin
                    ph_d = ph_q + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (enter_ro) begin
            state_d   = READOUT;
            row_d     = rs_q;
            col_d     = cs_q;
            ph_d      = '0;
            in_cols_d = 1'b0;
            cnt_d     = '0;
        end
        if (frame_reset) begin
            state_d   = IDLE;
            cnt_d     = '0;
            ms_d      = '0;
            ph_d      = '0;
            in_cols_d = 1'b0;
            row_d     = '0;
            col_d     = '0;
        end
    end

    assign ro_d = (state_d == READOUT);

    // Outputs are registered from next-state values so they align with state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt_q             <= '0;
            ms_q              <= '0;
            ph_q              <= '0;
            in_cols_q         <= 1'b0;
            row_q             <= '0;
            col_q             <= '0;
            rs_q              <= '0;
            re_q              <= '0;
            cs_q              <= '0;
            ce_q              <= '0;
            int_q             <= '0;
            frame_busy        <= 1'b0;
            frame_complete    <= 1'b0;
            row_addr          <= '0;
            col_addr          <= '0;
            row_clk_en        <= 1'b0;
            col_clk_en        <= 1'b0;
            gate_sel          <= 1'b0;
            reset_pulse       <= 1'b0;
            adc_start_trigger <= 1'b0;
        end else begin
            state             <= state_d;
            cnt_q             <= cnt_d;
            ms_q              <= ms_d;
            ph_q              <= ph_d;
            in_cols_q         <= in_cols_d;
            row_q             <= row_d;
            col_q             <= col_d;
            rs_q              <= rs_d;
            re_q              <= re_d;
            cs_q              <= cs_d;
            ce_q              <= ce_d;
            int_q             <= int_d;
            frame_busy        <= (state_d == RESET) || (state_d == INTEGRATE)
                                 || ro_d;
            frame_complete    <= (state_d == DONE);
            row_addr          <= ro_d ? row_d : 12'd0;
            col_addr          <= ro_d ? col_d : 12'd0;
            row_clk_en        <= ro_d && !in_cols_d && (ph_d == 16'd0);
            col_clk_en        <= ro_d && in_cols_d && (ph_d == DIV_LAST);
            gate_sel          <= ro_d;
            reset_pulse       <= (state_d == RESET);
            adc_start_trigger <= ro_d && in_cols_d && (ph_d == DIV_LAST);
        end
    end

endmodule

// File: tb/tb_timing_generator.sv
// Directed bench for timing_generator: table of ROI frames plus
// abort, reset and held-start sequences.
module tb_timing_generator;

    localparam int CPM = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_reset = 1'b0;
    logic [15:0] integration_time = '0;
    logic [11:0] row_start = '0, row_end = '0, col_start = '0, col_end = '0;
    logic        frame_busy, frame_complete;
    logic [11:0] row_addr, col_addr;
    logic        row_clk_en, col_clk_en, gate_sel, reset_pulse;
    logic        adc_start_trigger;
    logic [30:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    timing_generator #(
        .CYCLES_PER_MS(CPM),
        .RESET_CYCLES (16),
        .ROW_SETUP    (8),
        .COL_DIV      (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame_start      (frame_start),
        .frame_reset      (frame_reset),
        .integration_time (integration_time),
        .row_start        (row_start),
        .row_end          (row_end),
        .col_start        (col_start),
        .col_end          (col_end),
        .frame_busy       (frame_busy),
        .frame_complete   (frame_complete),
        .row_addr         (row_addr),
        .col_addr         (col_addr),
        .row_clk_en       (row_clk_en),
        .col_clk_en       (col_clk_en),
        .gate_sel         (gate_sel),
        .reset_pulse      (reset_pulse),
        .adc_start_trigger(adc_start_trigger)
    );

    always #5 clk = ~clk;

    assign outs = {frame_busy, frame_complete, row_addr, col_addr,
                   row_clk_en, col_clk_en, gate_sel, reset_pulse,
                   adc_start_trigger};

    typedef struct {
        logic [11:0] rs, re, cs, ce;
        logic [15:0] t;
        int          rows, cols, busy, integ;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge after the idle check.
    task automatic run_frame(input vec_t v, input string nm);
        int busy_c = 0, rp_c = 0, int_c = 0, px = 0, rclk = 0, fc_c = 0;
        bit done = 0;
        logic prev_adc = 1'b0;
        logic [11:0] er, ec;
        row_start = v.rs; row_end = v.re;
        col_start = v.cs; col_end = v.ce;
        integration_time = v.t;
        frame_start = 1'b1;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            if (n == 1) frame_start = 1'b0;
            busy_c += int'(frame_busy);
            rp_c   += int'(reset_pulse);
            rclk   += int'(row_clk_en);
            int_c  += int'(frame_busy && !reset_pulse && !gate_sel);
            if (adc_start_trigger) begin
                er = 12'(int'(v.rs) + px / v.cols);
                ec = 12'(int'(v.cs) + px % v.cols);
                chk({nm, "_addr"}, {8'd0, row_addr, col_addr},
                    {8'd0, er, ec});
                chk({nm, "_strobe"}, 32'({col_clk_en, gate_sel, prev_adc}),
                    32'd6);
                px++;
            end
            prev_adc = adc_start_trigger;
            if (frame_complete) begin
                fc_c++;
                chk({nm, "_busy_at_done"}, 32'(frame_busy), 32'd0);
                done = 1;
            end
        end
        frame_start = 1'b0;
        chk({nm, "_timeout"}, 32'(done), 32'd1);
        chk({nm, "_busy_cycles"}, busy_c, v.busy);
        chk({nm, "_reset_cycles"}, rp_c, 16);
        chk({nm, "_integ_cycles"}, int_c, v.integ);
        chk({nm, "_pixels"}, px, v.rows * v.cols);
        chk({nm, "_row_ticks"}, rclk, v.rows);
        chk({nm, "_complete"}, fc_c, 1);
        @(negedge clk);
        chk({nm, "_idle_after"}, 32'(outs), 32'd0);
    endtask

    initial begin
        int cnt;
        bit seen;
        vecs[0] = '{12'd0,    12'd1,    12'd0,    12'd1,    16'd0, 2, 2, 49, 1};
        vecs[1] = '{12'd2,    12'd2,    12'd5,    12'd7,    16'd1, 1, 3, 86, 50};
        vecs[2] = '{12'd5,    12'd3,    12'd1,    12'd2,    16'd0, 1, 2, 33, 1};
        vecs[3] = '{12'd1,    12'd3,    12'd4,    12'd2,    16'd2, 3, 1, 152, 100};
        vecs[4] = '{12'd4095, 12'd4095, 12'd4094, 12'd4095, 16'd0, 1, 2, 33, 1};

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(outs), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Abort mid-readout; frame_reset wins over frame_start.
        row_start = 0; row_end = 3; col_start = 0; col_end = 3;
        integration_time = 0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        cnt = 0;
        for (int n = 0; n < 300 && cnt < 2; n++) begin
            @(negedge clk);
            cnt += int'(adc_start_trigger);
        end
        chk("abort_reach_readout", 32'(cnt), 32'd2);
        frame_reset = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 32'(outs), 32'd0);
        frame_reset = 1'b0;
        frame_start = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (frame_complete || frame_busy) seen = 1;
        end
        chk("abort_no_activity", 32'(seen), 32'd0);
        run_frame(vecs[0], "after_abort");

        // Start held through DONE, dropped in IDLE: one frame only.
        for (int pass = 0; pass < 2; pass++) begin
            row_start = 0; row_end = 1; col_start = 0; col_end = 1;
            integration_time = 0;
            frame_start = 1'b1;
            seen = 0;
            for (int n = 0; n < 300 && !seen; n++) begin
                @(negedge clk);
                if (frame_complete) seen = 1;
            end
            chk($sformatf("held%0d_done", pass), 32'(seen), 32'd1);
            @(negedge clk);
            chk($sformatf("held%0d_idle", pass), 32'(frame_busy), 32'd0);
            if (pass == 0) begin
                frame_start = 1'b0;
                seen = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (frame_busy) seen = 1;
                end
                chk("held0_no_second", 32'(seen), 32'd0);
            end else begin
                @(negedge clk);
                frame_start = 1'b0;
                chk("held1_second_start", 32'(frame_busy), 32'd1);
                frame_reset = 1'b1;
                @(negedge clk);
                frame_reset = 1'b0;
                chk("held1_abort", 32'(outs), 32'd0);
            end
        end

        // rst_n during INTEGRATE, then immediate restart.
        row_start = 0; row_end = 1; col_start = 0; col_end = 1;
        integration_time = 2;
        frame_start = 1'b1;
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            frame_start = 1'b0;
            if (frame_busy && !reset_pulse) seen = 1;
        end
        chk("rst_reach_integ", 32'(seen), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_integ", 32'(outs), 32'd0);
        rst_n = 1'b1;
        run_frame(vecs[1], "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
